// File: rtl/matrix_pkg.sv
// Shared constants and types for the 3x3 matrix scalar-division pipeline.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package matrix_pkg;

  localparam int ELEM_W = 16;  // bits per matrix element
  localparam int N_ELEM = 9;   // elements per matrix, order a..i
  localparam int IDX_W  = 4;   // wide enough for 0..N_ELEM-1

  typedef enum logic [1:0] {
    LOAD0   = 2'd0,  // filling the dividend matrix
    LOAD1   = 2'd1,  // filling the divisor matrix
    PRESENT = 2'd2   // holding a complete pair for the divider
  } state_t;

  typedef logic [IDX_W-1:0] elem_idx_t;

endpackage

// File: rtl/mat_elem_counter.sv
// Element index counter 0..N_ELEM-1 with wrap, synchronous clear and last flag.
// Latency: idx updates one clock after inc/clr; last is combinational from idx.
// Backpressure: none; advances only when the caller asserts inc.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : advance the index (wraps from N_ELEM-1 to 0)
//   clr        : return to 0; wins over inc
//   idx        : current element index
//   last       : idx == N_ELEM-1
module mat_elem_counter
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  elem_idx_t r_idx;
  logic      w_last;

  assign w_last = (r_idx == IDX_W'(N_ELEM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (inc) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  assign idx  = r_idx;
  assign last = w_last;

endmodule

// File: rtl/matrix_operand_loader.sv
// Assembles a serial stream of 18 elements into dividend/divisor matrices for the divider.
// Latency: out_valid rises one clock after the 18th word transfer; no in_* -> out_* comb path.
// Backpressure: in_ready drops while a pair is presented; held until out_valid & out_ready.
//
// Optional feature: define DIVZERO_CHECK_EN to register a per-element divisor==0 flag;
// otherwise divzero is tied to zero.
//
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   flush                : synchronous abort of any partial or held load (highest priority)
//   in_valid/in_ready    : element word handshake, in_data carries the element
//   out_valid/out_ready  : operand pair handshake
//   mat0, mat1           : dividend / divisor, element k at [16k+15:16k] (k=0 is a)
//   divzero              : per-element divisor==0 flags, meaningful while out_valid=1
module matrix_operand_loader
  import matrix_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ELEM_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_ELEM*ELEM_W-1:0] mat0,
  output logic [N_ELEM*ELEM_W-1:0] mat1,
  output logic [N_ELEM-1:0]        divzero
);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [N_ELEM*ELEM_W-1:0]   r_mat0;
  logic [N_ELEM*ELEM_W-1:0]   r_mat1;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_last;
  logic                       w_word_xfer;
  logic                       w_pair_xfer;
  logic                       w_wr0;
  logic                       w_wr1;

  assign in_ready  = (r_state != PRESENT);
  assign out_valid = (r_state == PRESENT);

  // A flush in the same cycle suppresses capture of the presented word.
  assign w_word_xfer = in_valid & in_ready & ~flush;
  assign w_pair_xfer = out_valid & out_ready;
  assign w_wr0       = w_word_xfer & (r_state == LOAD0);
  assign w_wr1       = w_word_xfer & (r_state == LOAD1);

  mat_elem_counter u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_word_xfer),
    .clr   (flush),
    .idx   (w_idx),
    .last  (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = LOAD0;
    end else begin
      case (r_state)
        LOAD0:   if (w_word_xfer && w_last) w_state_nxt = LOAD1;
        LOAD1:   if (w_word_xfer && w_last) w_state_nxt = PRESENT;
        PRESENT: if (w_pair_xfer)           w_state_nxt = LOAD0;
        default:                            w_state_nxt = LOAD0;
      endcase
    end
  end

  // Matrix storage is not cleared by flush or pair transfer; the next load
  // overwrites every element before the pair is presented again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat0 <= '0;
      r_mat1 <= '0;
    end else begin
      for (int k = 0; k < N_ELEM; k++) begin
        if (w_wr0 && (w_idx == IDX_W'(k))) r_mat0[k*ELEM_W +: ELEM_W] <= in_data;
        if (w_wr1 && (w_idx == IDX_W'(k))) r_mat1[k*ELEM_W +: ELEM_W] <= in_data;
      end
    end
  end

  assign mat0 = r_mat0;
  assign mat1 = r_mat1;

`ifdef DIVZERO_CHECK_EN
  logic [N_ELEM-1:0] r_divzero;

  // Flag is captured alongside the divisor element so it needs no compare on the output side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divzero <= '0;
    end else if (flush) begin
      r_divzero <= '0;
    end else begin
      for (int k = 0; k < N_ELEM; k++) begin
        if (w_wr1 && (w_idx == IDX_W'(k))) r_divzero[k] <= (in_data == '0);
      end
    end
  end

  assign divzero = r_divzero;
`else
  assign divzero = '0;
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;

  localparam int EW = 16;
  localparam int NE = 9;
  localparam int MW = NE * EW;
`ifdef DIVZERO_CHECK_EN
  localparam bit DZ_ON = 1'b1;
`else
  localparam bit DZ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] mat0;
  logic [MW-1:0] mat1;
  logic [NE-1:0] divzero;

  matrix_operand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mat0      (mat0),
    .mat1      (mat1),
    .divzero   (divzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] m0;
    logic [MW-1:0] m1;
    logic [NE-1:0] dz;
  } pair_t;

  pair_t         exp_q[$];
  logic [EW-1:0] words[$];   // words accepted since the last pair boundary
  int            n_chk  = 0;
  int            n_fail = 0;
  bit            auto_rdy = 1'b0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after 18 accepted words, the first nine form the dividend
  // and the last nine the divisor, element k occupying bits [16k+15:16k].
  task automatic model_accept(input logic [EW-1:0] w);
    pair_t p;
    words.push_back(w);
    if (words.size() == 2 * NE) begin
      p.m0 = '0;
      p.m1 = '0;
      p.dz = '0;
      for (int k = 0; k < NE; k++) begin
        p.m0 = p.m0 | (MW'(words[k]) << (k * EW));
        p.m1 = p.m1 | (MW'(words[NE + k]) << (k * EW));
        if (DZ_ON && words[NE + k] == 0) p.dz[k] = 1'b1;
      end
      exp_q.push_back(p);
      words.delete();
    end
  endtask

  // Drive one word after optional random idle cycles; called at posedge+1.
  task automatic send_word(input logic [EW-1:0] w, input int gap_pct);
    int n;
    while ($urandom_range(0, 99) < gap_pct) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      @(posedge clk); #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(w);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", MW'(exp_q.size()), '0);
  endtask

  // Scoreboard monitor: every pair transfer must match the oldest expected pair.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pair: mat0=%0h with no expected pair", mat0);
      end else begin
        pair_t p;
        p = exp_q.pop_front();
        chk("sb_mat0", mat0, p.m0);
        chk("sb_mat1", mat1, p.m1);
        chk("sb_divzero", MW'(divzero), MW'(p.dz));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (auto_rdy) out_ready = ($urandom_range(0, 99) < 50);
  end

  logic [EW-1:0] s1_m0[NE] = '{16'd128, 16'd16, 16'd64, 16'd32, 16'd8, 16'd4, 16'd2, 16'd1, 16'd256};
  logic [EW-1:0] s1_m1[NE] = '{16'd4, 16'd2, 16'd1, 16'd8, 16'd16, 16'd32, 16'd64, 16'd128, 16'd512};

  initial begin
    pair_t         hold;
    logic [EW-1:0] w;

    // Reset state
    #3;
    chk("rst_out_valid", MW'(out_valid), '0);
    chk("rst_mat0", mat0, '0);
    chk("rst_mat1", mat1, '0);
    chk("rst_divzero", MW'(divzero), '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", MW'(in_ready), MW'(1));

    // Scenario 1: back-to-back stream, out_ready held low
    @(posedge clk); #1;
    for (int k = 0; k < NE; k++) send_word(s1_m0[k], 0);
    for (int k = 0; k < NE - 1; k++) send_word(s1_m1[k], 0);
    chk("s1_out_valid_before_last", MW'(out_valid), '0);
    send_word(s1_m1[NE-1], 0);
    chk("s1_out_valid_after_last", MW'(out_valid), MW'(1));
    chk("s1_in_ready_present", MW'(in_ready), '0);
    chk("s1_mat0_a", MW'(mat0[15:0]), MW'(128));
    chk("s1_mat1_a", MW'(mat1[15:0]), MW'(4));

    // Scenario 2: hold for 10 cycles, then accept
    hold = exp_q[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("s2_hold_valid", MW'(out_valid), MW'(1));
      chk("s2_hold_mat0", mat0, hold.m0);
      chk("s2_hold_mat1", mat1, hold.m1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("s2_out_valid_drop", MW'(out_valid), '0);
    chk("s2_in_ready_back", MW'(in_ready), MW'(1));
    auto_rdy = 1'b1;

    // Scenario 3: same data with ~30% idle cycles
    for (int k = 0; k < NE; k++) send_word(s1_m0[k], 30);
    for (int k = 0; k < NE; k++) send_word(s1_m1[k], 30);
    wait_drain();

    // Scenario 4: flush after 5 words, word presented with the flush is dropped
    for (int k = 0; k < 5; k++) send_word(EW'($urandom), 10);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hdead;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    words.delete();
    chk("s4_flush_valid", MW'(out_valid), '0);
    for (int k = 0; k < 2 * NE; k++) send_word(EW'($urandom), 10);
    wait_drain();

    // Scenario 5: reset pulse after 12 words
    for (int k = 0; k < 12; k++) send_word(EW'($urandom_range(1, 65535)), 10);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_mat0", mat0, '0);
    chk("s5_rst_mat1", mat1, '0);
    chk("s5_rst_valid", MW'(out_valid), '0);
    words.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("s5_rst_in_ready", MW'(in_ready), MW'(1));
    for (int k = 0; k < 2 * NE; k++) send_word(EW'($urandom), 10);
    wait_drain();

    // Scenario 6: divisor element e is zero
    auto_rdy  = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < NE; k++) send_word(EW'($urandom), 0);
    for (int k = 0; k < NE; k++) send_word((k == 4) ? 16'd0 : EW'($urandom_range(1, 65535)), 0);
    chk("s6_valid", MW'(out_valid), MW'(1));
    chk("s6_divzero", MW'(divzero), DZ_ON ? MW'(9'b000010000) : '0);
    auto_rdy = 1'b1;
    wait_drain();

    // Random pairs with occasional zero divisors
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 2 * NE; k++) begin
        w = ($urandom_range(0, 3) == 0) ? 16'd0 : EW'($urandom);
        send_word(w, 20);
      end
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
